// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display-controller bus bundling the value/control inputs and the
// registered display outputs of seg_scan_ctrl.
//   data_in    [31:0] value to display, nibble k -> digit k
//   freeze            1 = keep current snapshot at frame boundary
//   blank_lz          1 = suppress leading zero digits
//   dp_mask    [7:0]  1 = light decimal point of digit k
//   an         [7:0]  anode enables, active-low
//   seg        [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp                decimal point, active-low
//   frame_done        1-cycle pulse on each new frame
interface seg_scan_ctrl_if;
    logic [31:0] data_in;
    logic        freeze;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    modport master (output data_in, freeze, blank_lz, dp_mask, input an, seg, dp, frame_done);
    modport slave  (input data_in, freeze, blank_lz, dp_mask, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit common-anode 7-seg scan controller with per-frame snapshot,
// refresh prescaler, anti-ghost blank gap, leading-zero suppression and freeze hold.
//   clk    rising-edge system clock
//   reset  asynchronous, active-low
//   bus    seg_scan_ctrl_if.slave: data_in/freeze/blank_lz/dp_mask in,
//          an/seg/dp/frame_done out (all outputs registered)
module seg_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int BLANK   = 16,
    parameter int DIV_W   = 17
) (
    input logic            clk,
    input logic            reset,
    seg_scan_ctrl_if.slave bus
);
    logic [DIV_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_idx, w_idx_n;
    logic [31:0]      r_shadow, w_shadow_n, w_hi;
    logic             r_run, w_run_n;
    logic             w_tick, w_frame, w_gap, w_supp, w_dark;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp, r_fd;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_tick     = r_cnt == DIV_W'(CLK_DIV - 1);
    assign w_cnt_n    = w_tick ? '0 : r_cnt + 1'b1;
    assign w_idx_n    = w_tick ? r_idx + 3'd1 : r_idx;
    assign w_frame    = w_tick && r_idx == 3'd7;
    assign w_shadow_n = (w_frame && !bus.freeze) ? bus.data_in : r_shadow;
    // Display stays dark until the first tick after reset has passed.
    assign w_run_n    = r_run | w_tick;
    // Outputs reflect the state after this edge, hence the *_n terms.
    assign w_gap      = (BLANK != 0) && (w_cnt_n < DIV_W'(BLANK));
    // Nibbles idx..7 shifted down; all-zero means this digit is a leading zero.
    assign w_hi       = w_shadow_n >> {w_idx_n, 2'b00};
    assign w_supp     = bus.blank_lz && w_idx_n != 3'd0 && w_hi == 32'd0;
    assign w_dark     = !w_run_n || w_gap || w_supp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_idx    <= 3'd7;
            r_shadow <= '0;
            r_run    <= 1'b0;
            r_an     <= 8'hFF;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_fd     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_shadow <= w_shadow_n;
            r_run    <= w_run_n;
            r_fd     <= w_frame;
            r_an     <= w_dark ? 8'hFF : ~(8'b1 << w_idx_n);
            r_seg    <= w_dark ? 7'h7F : hex7(w_hi[3:0]);
            r_dp     <= w_dark ? 1'b1 : ~bus.dp_mask[w_idx_n];
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_fd;
endmodule
